ppu_text_console: RTL

PPU_TEXT_CONSOLE -- requirements
Module: ppu_text_console

---
 rtl/ppu_text_console_if.sv | 27 ++
 rtl/ppu_text_console.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ppu_text_console_if.sv
// CPU register port and text-buffer port of the text console.
// slave  : the console itself
// master : whatever drives the CPU side and hosts the text buffer
interface ppu_text_console_if #(
  parameter int ADDRW = 12
);
  logic             cpu_we;
  logic [1:0]       cpu_addr;
  logic [7:0]       cpu_wdata;
  logic [7:0]       cpu_rdata;
  logic             busy;
  logic             buf_we;
  logic [ADDRW-1:0] buf_addr;
  logic [7:0]       buf_wdata;
  logic [ADDRW-1:0] buf_rd_addr;
  logic [7:0]       buf_rdata;

  modport slave (
    input  cpu_we, cpu_addr, cpu_wdata, buf_rdata,
    output cpu_rdata, busy, buf_we, buf_addr, buf_wdata, buf_rd_addr
  );

  modport master (
    output cpu_we, cpu_addr, cpu_wdata, buf_rdata,
    input  cpu_rdata, busy, buf_we, buf_addr, buf_wdata, buf_rd_addr
  );
endinterface

// File: rtl/ppu_text_console.sv
// Text console controller: CPU register interface, cursor tracking, and
// clear / scroll / fill sequencers that drive a text buffer.
// Optional macro PPU_CONSOLE_AUTOSCROLL_EN: a row advance off the last row
// scrolls the screen instead of wrapping the cursor to row 0.
module ppu_text_console #(
  parameter int TEXTCOL = 64,
  parameter int TEXTROW = 37,
  parameter int ADDRW   = 12
) (
  input logic               clk,
  input logic               rst_n,
  ppu_text_console_if.slave bus
);
  localparam int               TOTAL   = TEXTCOL * TEXTROW;
  localparam int               NCOPY   = (TEXTROW - 1) * TEXTCOL;
  localparam logic [ADDRW-1:0] LAST_A  = ADDRW'(TOTAL - 1);
  localparam logic [ADDRW-1:0] NCOPY_A = ADDRW'(NCOPY);
  localparam logic [ADDRW-1:0] COL_A   = ADDRW'(TEXTCOL);
  localparam logic [ADDRW-1:0] ONE_A   = ADDRW'(1);
  localparam logic [7:0]       XMAX    = 8'(TEXTCOL - 1);
  localparam logic [7:0]       YMAX    = 8'(TEXTROW - 1);
  localparam logic [7:0]       SPACE   = 8'h20;

  typedef enum logic [1:0] {IDLE, CLEAR, SCROLL, FILL} state_e;

  state_e           state_q, state_d;
  logic [7:0]       cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [ADDRW-1:0] cnt_q, cnt_d;       // sequencer index
  logic [ADDRW-1:0] wptr_q, wptr_d;     // scroll destination for data arriving now
  logic             rd_vld_q, rd_vld_d; // buf_rdata carries a scroll source byte
  logic             buf_we_q, buf_we_d;
  logic [ADDRW-1:0] buf_addr_q, buf_addr_d, buf_rd_addr_q, buf_rd_addr_d;
  logic [7:0]       buf_wdata_q, buf_wdata_d;
  logic [ADDRW-1:0] cur_addr;
  logic             printable, adv, start_scroll;

  assign cur_addr  = ADDRW'(cur_y_q) * COL_A + ADDRW'(cur_x_q);
  assign printable = (bus.cpu_wdata >= 8'h20) && (bus.cpu_wdata != 8'h7F);

  // Next-state: CPU command decode in IDLE, address sequencing otherwise
  always_comb begin
    state_d       = state_q;
    cur_x_d       = cur_x_q;
    cur_y_d       = cur_y_q;
    cnt_d         = cnt_q;
    wptr_d        = wptr_q;
    rd_vld_d      = 1'b0;
    buf_we_d      = 1'b0;
    buf_addr_d    = buf_addr_q;
    buf_wdata_d   = buf_wdata_q;
    buf_rd_addr_d = buf_rd_addr_q;
    adv           = 1'b0;
    start_scroll  = 1'b0;
    case (state_q)
      IDLE: if (bus.cpu_we) begin
        case (bus.cpu_addr)
          2'd0: begin
            if (printable) begin
              buf_we_d    = 1'b1;
              buf_addr_d  = cur_addr;
              buf_wdata_d = bus.cpu_wdata;
              if (cur_x_q == XMAX) adv = 1'b1;
              else                 cur_x_d = cur_x_q + 8'd1;
            end else if (bus.cpu_wdata == 8'h0A) begin
              adv = 1'b1;
            end else if (bus.cpu_wdata == 8'h0D) begin
              cur_x_d = 8'd0;
            end else if (bus.cpu_wdata == 8'h08 && cur_x_q != 8'd0) begin
              cur_x_d     = cur_x_q - 8'd1;
              buf_we_d    = 1'b1;
              buf_addr_d  = cur_addr - ONE_A;
              buf_wdata_d = SPACE;
            end
          end
          2'd1: cur_x_d = (bus.cpu_wdata > XMAX) ? XMAX : bus.cpu_wdata;
          2'd2: cur_y_d = (bus.cpu_wdata > YMAX) ? YMAX : bus.cpu_wdata;
          default: begin
            if (bus.cpu_wdata == 8'h01) begin
              state_d = CLEAR;
              cnt_d   = '0;
            end else if (bus.cpu_wdata == 8'h02) begin
              start_scroll = 1'b1;
            end
          end
        endcase
      end
      CLEAR: begin
        buf_we_d    = 1'b1;
        buf_addr_d  = cnt_q;
        buf_wdata_d = SPACE;
        if (cnt_q == LAST_A) begin
          state_d = IDLE;
          cur_x_d = 8'd0;
          cur_y_d = 8'd0;
        end else begin
          cnt_d = cnt_q + ONE_A;
        end
      end
      SCROLL: begin
        // Source byte for wptr_q arrives this cycle; write it out
        if (rd_vld_q) begin
          buf_we_d    = 1'b1;
          buf_addr_d  = wptr_q;
          buf_wdata_d = bus.buf_rdata;
        end
        if (cnt_q != NCOPY_A) begin
          rd_vld_d      = 1'b1;
          wptr_d        = cnt_q;
          cnt_d         = cnt_q + ONE_A;
          // Park the read address in range once the last source is issued
          buf_rd_addr_d = (cnt_q + ONE_A == NCOPY_A) ? '0 : cnt_q + ONE_A + COL_A;
        end else begin
          state_d = FILL;
          cnt_d   = NCOPY_A;
        end
      end
      default: begin // FILL: blank the last row
        buf_we_d    = 1'b1;
        buf_addr_d  = cnt_q;
        buf_wdata_d = SPACE;
        if (cnt_q == LAST_A) state_d = IDLE;
        else                 cnt_d   = cnt_q + ONE_A;
      end
    endcase
    // Row advance shared by LF and column wrap
    if (adv) begin
      cur_x_d = 8'd0;
      if (cur_y_q == YMAX) begin
`ifdef PPU_CONSOLE_AUTOSCROLL_EN
        cur_y_d      = YMAX;
        start_scroll = 1'b1;
`else
        cur_y_d      = 8'd0;
`endif
      end else begin
        cur_y_d = cur_y_q + 8'd1;
      end
    end
    // First source address goes out on the first SCROLL cycle
    if (start_scroll) begin
      state_d       = SCROLL;
      cnt_d         = '0;
      buf_rd_addr_d = COL_A;
    end
  end

  // State and registered outputs; reset aborts any running sequence
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cur_x_q       <= '0;
      cur_y_q       <= '0;
      cnt_q         <= '0;
      wptr_q        <= '0;
      rd_vld_q      <= 1'b0;
      buf_we_q      <= 1'b0;
      buf_addr_q    <= '0;
      buf_wdata_q   <= '0;
      buf_rd_addr_q <= '0;
    end else begin
      state_q       <= state_d;
      cur_x_q       <= cur_x_d;
      cur_y_q       <= cur_y_d;
      cnt_q         <= cnt_d;
      wptr_q        <= wptr_d;
      rd_vld_q      <= rd_vld_d;
      buf_we_q      <= buf_we_d;
      buf_addr_q    <= buf_addr_d;
      buf_wdata_q   <= buf_wdata_d;
      buf_rd_addr_q <= buf_rd_addr_d;
    end
  end

  // Register readback
  always_comb begin
    case (bus.cpu_addr)
      2'd1:    bus.cpu_rdata = cur_x_q;
      2'd2:    bus.cpu_rdata = cur_y_q;
      2'd3:    bus.cpu_rdata = {7'b0, state_q != IDLE};
      default: bus.cpu_rdata = 8'h00;
    endcase
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.buf_we      = buf_we_q;
  assign bus.buf_addr    = buf_addr_q;
  assign bus.buf_wdata   = buf_wdata_q;
  assign bus.buf_rd_addr = buf_rd_addr_q;
endmodule
